raw10_line_unpacker: RTL and testbench

- Sits directly downstream of the MIPI receiver.
- Takes its 32-bit byte-aligned payload words (2 lanes x 2 bytes, byte0 in data_i[7:0]) and unpacks CSI-2 RAW10 into 4-pixel groups of 10-bit pixels.
- Tracks pixel x and line y per group and produces the group write address for the raw frame RAM.
- Runs entirely in the sys_clk (100 MHz) domain.

---
 rtl/raw10_pkg.sv | 10 +
 rtl/raw10_group_decode.sv | 20 ++
 rtl/raw10_line_unpacker.sv | 116 +++++++++++
 tb/tb_raw10_line_unpacker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/raw10_pkg.sv
// RAW10 unpacker shared definitions.
// Group geometry and pixel-group bundle types.
package raw10_pkg;
  localparam int RAW10_BYTES_PER_GROUP = 5;
  localparam int PIX_PER_GROUP = 4;
  localparam int PIX_W = 10;

  typedef logic [PIX_PER_GROUP*PIX_W-1:0] pix_grp_t;
  typedef logic [RAW10_BYTES_PER_GROUP*8-1:0] raw_grp_t;
endpackage

// File: rtl/raw10_group_decode.sv
// RAW10 group decode: 5 packed bytes to 4 pixels.
// Byte 4 carries the two LSBs of each pixel.
module raw10_group_decode
  import raw10_pkg::*;
(
  input  raw_grp_t i_bytes,
  output pix_grp_t o_pix
);

  always_comb begin
    o_pix = '0;
    for (int n = 0; n < PIX_PER_GROUP; n++) begin
      o_pix[n*PIX_W +: PIX_W] = {
        i_bytes[n*8 +: 8],
        i_bytes[32 + 2*n +: 2]
      };
    end
  end

endmodule

// File: rtl/raw10_line_unpacker.sv
// CSI-2 RAW10 line unpacker: byte buffer, x/y tracking,
// frame RAM group address and sticky line-length error.
module raw10_line_unpacker
  import raw10_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic [31:0]    data_i,
  input  logic           data_valid,
  output logic [39:0]    pix_o,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [31:0]    ram_adress,
  output logic           len_err
);

  localparam logic [X_W-1:0] LPG =
    X_W'(LINE_PIXELS / PIX_PER_GROUP);

  logic [63:0]    r_buf;
  logic [3:0]     r_cnt;
  logic [X_W-1:0] r_grp;
  logic [Y_W-1:0] r_y;
  logic           r_first;
  logic           r_err;

  logic           w_clr;
  logic [3:0]     w_base;
  logic           w_first_b;
  logic [Y_W-1:0] w_y_b;
  logic [Y_W-1:0] w_y;
  logic [X_W-1:0] w_grp_b;
  logic [6:0]     w_sh;
  logic [63:0]    w_mask;
  logic [63:0]    w_cat;
  logic           w_emit;
  logic           w_len_bad;
  logic           w_over;
  pix_grp_t       w_pix;

  // Frame/line events act before the word of the same cycle.
  assign w_clr     = frame_start | line_start;
  assign w_base    = w_clr ? 4'd0 : r_cnt;
  assign w_first_b = frame_start | r_first;
  assign w_y_b     = frame_start ? '0 : r_y;
  assign w_y       = (line_start && !w_first_b)
                   ? w_y_b + 1'b1 : w_y_b;
  assign w_grp_b   = w_clr ? '0 : r_grp;

  assign w_sh   = {w_base, 3'b000};
  assign w_mask = ~({64{1'b1}} << w_sh);
  assign w_cat  = (r_buf & w_mask)
                | ({32'b0, data_i} << w_sh);
  assign w_emit = data_valid && (w_base != 4'd0);

  assign w_len_bad = line_start && !w_first_b &&
                     ((r_cnt != 4'd0) || (r_grp != LPG));
  assign w_over    = w_emit && (w_grp_b >= LPG);

  raw10_group_decode u_dec (
    .i_bytes (w_cat[39:0]),
    .o_pix   (w_pix)
  );

  assign len_err = r_err;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_grp      <= '0;
      r_y        <= '0;
      r_first    <= 1'b1;
      r_err      <= 1'b0;
      pix_o      <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      ram_adress <= '0;
    end else begin
      pix_valid <= w_emit;
      if (w_emit) begin
        pix_o      <= w_pix;
        pix_x      <= {w_grp_b[X_W-3:0], 2'b00};
        pix_y      <= w_y;
        ram_adress <= 32'(w_y) * 32'(LPG)
                    + 32'(w_grp_b);
      end
      if (data_valid) begin
        if (w_emit) begin
          r_buf <= w_cat >> 40;
          r_cnt <= 4'(w_base - 4'd1);
        end else begin
          r_buf <= w_cat;
          r_cnt <= 4'd4;
        end
      end else if (w_clr) begin
        r_buf <= '0;
        r_cnt <= '0;
      end
      r_grp   <= w_emit ? w_grp_b + 1'b1 : w_grp_b;
      r_y     <= w_y;
      r_first <= w_first_b & ~line_start;
      r_err   <= (frame_start ? 1'b0 : r_err)
               | w_len_bad | w_over;
    end
  end

endmodule

// File: tb/tb_raw10_line_unpacker.sv
// Scoreboard bench for raw10_line_unpacker.
// Byte-queue reference model, randomized payload and events.
module tb_raw10_line_unpacker;
  localparam int LP  = 640;
  localparam int LPG = LP / 4;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data_i = '0;
  logic [39:0] pix_o;
  logic        pix_valid;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [31:0] ram_adress;
  logic        len_err;

  always #5 sys_clk = ~sys_clk;

  raw10_line_unpacker #(
    .LINE_PIXELS (LP),
    .X_W         (12),
    .Y_W         (12)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .data_i      (data_i),
    .data_valid  (data_valid),
    .pix_o       (pix_o),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .ram_adress  (ram_adress),
    .len_err     (len_err)
  );

  typedef struct {
    logic [39:0] p;
    int          x;
    int          y;
    int          a;
  } exp_t;

  exp_t         sb[$];
  byte unsigned mq[$];
  int           m_grp;
  int           m_y;
  bit           m_first;
  bit           m_err;
  int           checks = 0;
  int           errors = 0;
  int           pulses = 0;
  logic [39:0]  last_pix = '0;

  task automatic chk(string name,
                     logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_grp   = 0;
    m_y     = 0;
    m_first = 1'b1;
    m_err   = 1'b0;
  endfunction

  task automatic cyc(bit fs, bit ls, bit dv,
                     logic [31:0] d);
    exp_t         e;
    byte unsigned b[5];
    if (fs) model_reset();
    if (ls) begin
      if (!m_first && (mq.size() != 0 || m_grp != LPG))
        m_err = 1'b1;
      if (m_first) m_first = 1'b0;
      else m_y = (m_y + 1) % 4096;
      mq.delete();
      m_grp = 0;
    end
    if (dv) begin
      for (int k = 0; k < 4; k++)
        mq.push_back(d[8*k +: 8]);
      if (mq.size() >= 5) begin
        for (int k = 0; k < 5; k++)
          b[k] = mq.pop_front();
        e.p = '0;
        for (int n = 0; n < 4; n++)
          e.p[n*10 +: 10] = 10'(int'(b[n]) * 4 +
            ((int'(b[4]) >> (2*n)) & 3));
        e.x = (m_grp * 4) % 4096;
        e.y = m_y;
        e.a = m_y * LPG + m_grp;
        if (m_grp >= LPG) m_err = 1'b1;
        m_grp++;
        sb.push_back(e);
      end
    end
    frame_start = fs;
    line_start  = ls;
    data_valid  = dv;
    data_i      = d;
    @(posedge sys_clk);
    #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    data_valid  = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic word();
    cyc(1'b0, 1'b0, 1'b1, $urandom);
  endtask

  task automatic drain(string name);
    idle();
    chk(name, sb.size(), 0);
  endtask

  task automatic chk_rst_outputs(string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_o"}, pix_o, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_ram"}, ram_adress, 0);
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (reset && pix_valid) begin
        pulses++;
        last_pix = pix_o;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_group: pix_o=%0h x=%0d",
                   pix_o, pix_x);
        end else begin
          e = sb.pop_front();
          chk("pix_o", pix_o, e.p);
          chk("pix_x", pix_x, 12'(e.x));
          chk("pix_y", pix_y, 12'(e.y));
          chk("ram_adress", ram_adress, 32'(e.a));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int walk_exp[5];
    walk_exp = '{0, 1, 2, 3, 4};
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk_rst_outputs("reset");
    reset = 1'b1;

    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h10204080);
    cyc(1'b0, 1'b0, 1'b1, 32'h000000E4);
    drain("single_drain");
    chk("single_pix", last_pix,
        {10'h043, 10'h082, 10'h101, 10'h200});

    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    pulses = 0;
    repeat (200) word();
    drain("full_drain");
    chk("full_pulses", pulses, 160);
    chk("full_pix_x_last", pix_x, 636);
    cyc(1'b0, 1'b1, 1'b1, $urandom);
    chk("full_len_err", len_err, 0);
    word();
    idle();
    chk("line1_ram", ram_adress, 160);
    chk("line1_x", pix_x, 0);
    chk("line1_y", pix_y, 1);

    repeat (197) word();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("short_len_err", len_err, 1);

    p0 = pulses;
    for (int w = 0; w < 5; w++) begin
      word();
      idle();
      repeat ($urandom_range(0, 3)) idle();
      chk($sformatf("walk_%0d", w), pulses - p0,
          walk_exp[w]);
    end
    drain("walk_drain");
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fs_clears_err", len_err, 0);

    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (205) word();
    drain("over_drain");
    chk("over_len_err", len_err, 1);
    chk("over_pix_x", pix_x, 652);

    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0,
          $urandom);
    drain("rand_drain");
    chk("rand_len_err", len_err, m_err);

    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) word();
    idle();
    @(negedge sys_clk);
    #2;
    reset = 1'b0;
    #1;
    chk_rst_outputs("async");
    model_reset();
    @(posedge sys_clk);
    #1;
    reset = 1'b1;
    word();
    idle();
    chk("post_rst_none", sb.size(), 0);
    word();
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
